// File: rtl/pow5_pkg.sv
// Shared types and constants for the power-of-5 unit.
// Sizes the sequential multiply count and the pipeline depth.
package pow5_pkg;

  localparam int W            = 18;
  localparam int SEQ_MULTS    = 4;
  localparam int PIPE_LATENCY = 3;

  typedef logic [W-1:0] data_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/pow5_seq_fsm.sv
// Multicycle n^5 engine: one multiplier reused for four passes behind a run/ready handshake.
// The result register holds the last completed value until the next completion.
module pow5_seq_fsm
  import pow5_pkg::*;
#(
  parameter int W = pow5_pkg::W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_run,
  input  logic [W-1:0] i_n,
  output logic         o_ready,
  output logic [W-1:0] o_result
);

  localparam int CNT_W = $clog2(SEQ_MULTS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SEQ_MULTS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_n;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_result;
  logic [W-1:0]     w_prod;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             w_start;
  logic             w_done;

  assign w_prod = r_acc * r_n;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_run) begin
          w_start      = 1'b1;
          w_state_next = BUSY;
        end else begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == LAST_CNT) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = BUSY;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture on start; multiply-accumulate while busy, publish on the last pass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n      <= {W{1'b0}};
      r_acc    <= {W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_result <= {W{1'b0}};
      r_ready  <= 1'b1;
    end else if (w_start) begin
      r_n     <= i_n;
      r_acc   <= i_n;
      r_cnt   <= {CNT_W{1'b0}};
      r_ready <= 1'b0;
    end else if (r_state == BUSY) begin
      r_acc <= w_prod;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_done) begin
        r_result <= w_prod;
        r_ready  <= 1'b1;
      end
    end
  end

  assign o_ready  = r_ready;
  assign o_result = r_result;

endmodule

// File: rtl/pow_5_unit.sv
// n^5 mod 2^W via sequential, combinational and 3-stage pipelined engines on one operand bus.
// Optional POW5_PIPE_VALID_EN adds a valid bit that gates the pipeline register loads.
module pow_5_unit
  import pow5_pkg::*;
#(
  parameter int W = pow5_pkg::W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         run,
  input  logic [W-1:0] n,
`ifdef POW5_PIPE_VALID_EN
  input  logic         pipe_in_valid,
  output logic         pipe_out_valid,
`endif
  output logic         ready,
  output logic [W-1:0] n_pow_5_seq,
  output logic [W-1:0] n_pow_5_comb,
  output logic [W-1:0] n_pow_5_pipe
);

  logic [W-1:0] w_sq;
  logic [W-1:0] w_q4;
  logic [W-1:0] r_s1_n;
  logic [W-1:0] r_s1_sq;
  logic [W-1:0] r_s2_n;
  logic [W-1:0] r_s2_q4;
  logic [W-1:0] r_pipe;
  logic         w_ld1;
  logic         w_ld2;
  logic         w_ld3;

  pow5_seq_fsm #(
    .W(W)
  ) u_seq (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_run   (run),
    .i_n     (n),
    .o_ready (ready),
    .o_result(n_pow_5_seq)
  );

  assign w_sq         = n * n;
  assign w_q4         = w_sq * w_sq;
  assign n_pow_5_comb = w_q4 * n;

`ifdef POW5_PIPE_VALID_EN
  logic [PIPE_LATENCY-1:0] r_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= {PIPE_LATENCY{1'b0}};
    end else begin
      r_valid <= {r_valid[PIPE_LATENCY-2:0], pipe_in_valid};
    end
  end

  assign w_ld1          = pipe_in_valid;
  assign w_ld2          = r_valid[0];
  assign w_ld3          = r_valid[1];
  assign pipe_out_valid = r_valid[PIPE_LATENCY-1];
`else
  assign w_ld1 = 1'b1;
  assign w_ld2 = 1'b1;
  assign w_ld3 = 1'b1;
`endif

  // Square, then fourth power, then multiply back by the delayed operand.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_n  <= {W{1'b0}};
      r_s1_sq <= {W{1'b0}};
      r_s2_n  <= {W{1'b0}};
      r_s2_q4 <= {W{1'b0}};
      r_pipe  <= {W{1'b0}};
    end else begin
      if (w_ld1) begin
        r_s1_n  <= n;
        r_s1_sq <= w_sq;
      end
      if (w_ld2) begin
        r_s2_n  <= r_s1_n;
        r_s2_q4 <= r_s1_sq * r_s1_sq;
      end
      if (w_ld3) begin
        r_pipe <= r_s2_q4 * r_s2_n;
      end
    end
  end

  assign n_pow_5_pipe = r_pipe;

endmodule

// File: tb/tb_pow_5_unit.sv
// Directed self-checking bench for pow_5_unit (default build, valid feature off).
module tb_pow_5_unit;

  localparam int W = 18;

  logic         clock;
  logic         reset_n;
  logic         run;
  logic [W-1:0] n;
  logic         ready;
  logic [W-1:0] n_pow_5_seq;
  logic [W-1:0] n_pow_5_comb;
  logic [W-1:0] n_pow_5_pipe;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pow5_tab [8];

  pow_5_unit #(.W(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .n           (n),
    .ready       (ready),
    .n_pow_5_seq (n_pow_5_seq),
    .n_pow_5_comb(n_pow_5_comb),
    .n_pow_5_pipe(n_pow_5_pipe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    n       = 18'd3;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready); end
    checks++;
    if (n_pow_5_seq !== 18'd0) begin errors++; $display("FAIL reset_seq got %0d want 0", n_pow_5_seq); end
    checks++;
    if (n_pow_5_pipe !== 18'd0) begin errors++; $display("FAIL reset_pipe got %0d want 0", n_pow_5_pipe); end
    checks++;
    if (n_pow_5_comb !== 18'd243) begin errors++; $display("FAIL reset_comb got %0d want 243", n_pow_5_comb); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_comb();
    for (int i = 0; i < 8; i++) begin
      n = W'(i);
      #1;
      checks++;
      if (n_pow_5_comb !== pow5_tab[i]) begin
        errors++;
        $display("FAIL comb_n%0d got %0d want %0d", i, n_pow_5_comb, pow5_tab[i]);
      end
    end
    n = 18'd13;
    #1;
    checks++;
    if (n_pow_5_comb !== 18'd109149) begin
      errors++;
      $display("FAIL comb_trunc13 got %0d want 109149", n_pow_5_comb);
    end
    @(negedge clock);
  endtask

  task automatic test_seq_handshake();
    n   = 18'd3;
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    n   = 18'd7;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL hs_busy_ready c%0d got %0b want 0", c, ready); end
      checks++;
      if (n_pow_5_seq !== 18'd0) begin errors++; $display("FAIL hs_hold_seq c%0d got %0d want 0", c, n_pow_5_seq); end
      run = (c == 1 || c == 2) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    run = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL hs_done_ready got %0b want 1", ready); end
    checks++;
    if (n_pow_5_seq !== 18'd243) begin errors++; $display("FAIL hs_result got %0d want 243", n_pow_5_seq); end
    @(negedge clock);
    checks++;
    if (ready !== 1'b1 || n_pow_5_seq !== 18'd243) begin
      errors++;
      $display("FAIL hs_idle_hold got ready=%0b seq=%0d want ready=1 seq=243", ready, n_pow_5_seq);
    end
  endtask

  task automatic test_seq_back_to_back();
    logic [W-1:0] exp_seq;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (ready !== ((i % 5) == 0)) begin
        errors++;
        $display("FAIL b2b_ready i%0d got %0b want %0b", i, ready, ((i % 5) == 0));
      end
      exp_seq = (i < 5) ? 18'd243 : pow5_tab[(5 * ((i / 5) - 1)) & 7];
      checks++;
      if (n_pow_5_seq !== exp_seq) begin
        errors++;
        $display("FAIL b2b_seq i%0d got %0d want %0d", i, n_pow_5_seq, exp_seq);
      end
      run = ready;
      n   = W'(i & 7);
    end
    @(negedge clock);
    run = 1'b0;
    checks++;
    if (ready !== 1'b1 || n_pow_5_seq !== 18'd1024) begin
      errors++;
      $display("FAIL b2b_last got ready=%0b seq=%0d want ready=1 seq=1024", ready, n_pow_5_seq);
    end
    @(negedge clock);
  endtask

  task automatic test_pipe_stream();
    for (int j = 0; j < 11; j++) begin
      if (j >= 3) begin
        checks++;
        if (n_pow_5_pipe !== pow5_tab[j - 3]) begin
          errors++;
          $display("FAIL pipe_out j%0d got %0d want %0d", j, n_pow_5_pipe, pow5_tab[j - 3]);
        end
      end
      n = (j < 8) ? W'(j) : 18'd0;
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_op();
    int waited;
    n   = 18'd5;
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", ready); end
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got %0b want 1", ready); end
    checks++;
    if (n_pow_5_seq !== 18'd0) begin errors++; $display("FAIL mid_async_seq got %0d want 0", n_pow_5_seq); end
    checks++;
    if (n_pow_5_pipe !== 18'd0) begin errors++; $display("FAIL mid_async_pipe got %0d want 0", n_pow_5_pipe); end
    @(negedge clock);
    reset_n = 1'b1;
    n       = 18'd2;
    run     = 1'b1;
    @(negedge clock);
    run    = 1'b0;
    waited = 0;
    while (ready !== 1'b1 && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (waited != 4) begin errors++; $display("FAIL mid_rerun_latency got %0d want 4", waited); end
    checks++;
    if (n_pow_5_seq !== 18'd32) begin errors++; $display("FAIL mid_rerun_result got %0d want 32", n_pow_5_seq); end
  endtask

  initial begin
    pow5_tab[0] = 18'd0;
    pow5_tab[1] = 18'd1;
    pow5_tab[2] = 18'd32;
    pow5_tab[3] = 18'd243;
    pow5_tab[4] = 18'd1024;
    pow5_tab[5] = 18'd3125;
    pow5_tab[6] = 18'd7776;
    pow5_tab[7] = 18'd16807;
    test_reset();
    test_comb();
    test_seq_handshake();
    test_seq_back_to_back();
    test_pipe_stream();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pow_5_unit.md
Name: pow_5_unit

Overview:
Computes n^5 modulo 2^W using three independent engines that share one input bus.
- Sequential multicycle engine with a run/ready handshake (one multiplier reused).
- Purely combinational engine.
- Fixed-latency pipelined engine accepting one operand per clock.

All three produce identical values, so the block serves as an area/latency comparison reference and as a drop-in power-of-5 unit for datapaths.

Parameters:
- W, 18, operand and result width; all products truncated to W bits.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- run  input  1  start request for the sequential engine.
- n  input  W  operand (unsigned), shared by all engines.
- ready  output  1  sequential engine idle; n_pow_5_seq is valid.
- n_pow_5_seq  output  W  sequential result (registered).
- n_pow_5_comb  output  W  combinational result.
- n_pow_5_pipe  output  W  pipelined result (registered).

Behaviour:
- Arithmetic: unsigned; every intermediate product is truncated to W bits (mod 2^W). There is no overflow flag.

Combinational engine:
- n_pow_5_comb = n*n*n*n*n mod 2^W, with zero latency.
- It has no state and ignores reset.

Sequential engine:
- FSM states are IDLE and BUSY.
- Reset: state IDLE, ready=1, n_pow_5_seq=0, internal accumulator, operand register and counter all 0.
- IDLE with run=1 at a rising edge E0:
  - n_reg<=n, acc<=n, cnt<=0;
  - go to BUSY; ready=0 after E0.
- BUSY, each edge: acc<=acc*n_reg, cnt<=cnt+1. Four multiplies occur at E1..E4.
- At E4 (4th multiply):
  - n_pow_5_seq<=n^5 mod 2^W;
  - ready<=1; state<=IDLE.
- Total latency is 4 cycles from the capture edge.
- run is ignored while BUSY. Changes to n after E0 do not affect the result.
- n_pow_5_seq holds the previous result throughout BUSY and until the next completion.
- run=1 in IDLE is accepted on the same edge at which ready is first seen high, so there are no mandatory idle cycles. Back-to-back throughput is one result per 5 cycles.
- reset_n asserted mid-operation aborts immediately to IDLE with reset values; the partial result is discarded.

Pipelined engine (3 stages, every clock):
- Edge k: s1_n<=n; s1_sq<=n*n.
- Edge k+1: s2_n<=s1_n; s2_q4<=s1_sq*s1_sq.
- Edge k+2: n_pow_5_pipe<=s2_q4*s2_n.
- Latency is 3 cycles and throughput is 1 result per cycle.
- All pipeline registers reset to 0 asynchronously. After reset, the output is 0 until the first operand drains through.

Optional Feature:
POW5_PIPE_VALID_EN
- With the macro defined:
  - adds input pipe_in_valid (1) and output pipe_out_valid (1);
  - a valid bit travels with each stage;
  - each stage's data registers load only when the preceding valid bit is 1 (stage 1 uses pipe_in_valid), otherwise they hold;
  - pipe_out_valid is pipe_in_valid delayed 3 cycles;
  - valid bits reset to 0.
- Without the macro: neither port exists, and the pipeline loads every cycle as described above.

Decomposition:
- Package pow5_pkg contains:
  - localparam W=18 default and data_t = logic [W-1:0];
  - SEQ_MULTS=4 and PIPE_LATENCY=3;
  - the FSM state enum (IDLE, BUSY).
- One natural sub-module: pow5_seq_fsm, holding the sequential engine (FSM, counter, accumulator, result register, run/ready).
- The combinational and pipelined engines stay inline in pow_5_unit.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles. Expect ready=1, n_pow_5_seq=0, n_pow_5_pipe=0, n_pow_5_comb=n^5 immediately.
- Comb sweep: n=0..7. Expect n_pow_5_comb = 0,1,32,243,1024,3125,7776,16807. Then n=13 -> 109149 (truncation).
- Seq handshake:
  - n=3, run=1 for one edge, then n changed to 7 while busy;
  - expect ready low for 4 cycles, then ready=1 and n_pow_5_seq=243;
  - run pulses during BUSY are ignored.
- Seq back-to-back: drive run<=ready each cycle, n=i&7. Expect a new result every 5 cycles matching n^5 of the captured operand, and the result held between completions.
- Pipe stream: n=0..7 one per cycle. Expect n_pow_5_pipe to present the same sequence 3 cycles later, one per cycle.
- Reset mid-operation: assert reset_n during BUSY after n=5 is accepted. Expect ready=1 and n_pow_5_seq=0 asynchronously. The next run with n=2 yields 32.
